// File: rtl/iobus_uart_tx.sv
// iobus_uart_tx: memory-mapped 8N1 UART transmitter on the OTTER IOBUS.
// CPU stores to TXDATA fill a small FIFO; a bit-timing FSM drains it onto TX.
// STATUS and CTRL are read back through a registered RD_DATA port.
module iobus_uart_tx #(
    parameter int          CLK_RATE  = 50,
    parameter int          BAUD      = 115200,
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        TX,
    output logic        IRQ
);

    // Cycles per bit, truncated.
    localparam int DIV    = (CLK_RATE * 1_000_000) / BAUD;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    localparam logic [31:0] ADDR_TXDATA = BASE_ADDR;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'h8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Register state
    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                tx_en_q, tx_en_d;
    logic                irq_en_q, irq_en_d;
    logic                irq_q, irq_d;
    logic [31:0]         rd_data_q, rd_data_d;

    logic [7:0]          fifo_mem [DEPTH];

    logic                wr_txdata;
    logic                wr_status;
    logic                wr_ctrl;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                fifo_full;

    // Only the low byte of store data is ever transmitted.
    logic [23:0]         unused_out_bits;
    assign unused_out_bits = IOBUS_OUT[31:8];

    // Exact 32-bit compare also rejects any non-word-aligned address.
    assign wr_txdata  = IOBUS_WR && (IOBUS_ADDR == ADDR_TXDATA);
    assign wr_status  = IOBUS_WR && (IOBUS_ADDR == ADDR_STATUS);
    assign wr_ctrl    = IOBUS_WR && (IOBUS_ADDR == ADDR_CTRL);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // Bit-timing FSM: next state, baud counter, shifter, pop request, TX level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_en_q && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
        // TX flop follows the level of the state being entered, so the line
        // changes on the same edge as the state.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping: a push into a full FIFO is allowed only alongside a pop.
    always_comb begin
        push       = 1'b0;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (wr_txdata) begin
            if (!fifo_full || pop) begin
                push = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (wr_status) begin
            overflow_d = 1'b0;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control register, interrupt level and registered read mux.
    always_comb begin
        logic [31:0] count_ext;
        logic [3:0]  count_clamp;
        tx_en_d     = tx_en_q;
        irq_en_d    = irq_en_q;
        rd_data_d   = 32'h0;
        count_ext   = 32'(count_q);
        count_clamp = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
        if (wr_ctrl) begin
            tx_en_d  = IOBUS_OUT[0];
            irq_en_d = IOBUS_OUT[1];
        end
        irq_d = irq_en_q && fifo_empty && (state_q == S_IDLE);
        if (IOBUS_ADDR == ADDR_STATUS) begin
            rd_data_d = {24'h0, count_clamp, overflow_q,
                         (state_q != S_IDLE), fifo_empty, fifo_full};
        end else if (IOBUS_ADDR == ADDR_CTRL) begin
            rd_data_d = {30'h0, irq_en_q, tx_en_q};
        end
    end

    // FIFO storage: written without reset so it can map onto RAM primitives.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= IOBUS_OUT[7:0];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_en_q    <= 1'b1;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            rd_data_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_en_q    <= tx_en_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign RD_DATA = rd_data_q;
    assign TX      = tx_q;
    assign IRQ     = irq_q;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Testbench for iobus_uart_tx: bus tasks, a frame receiver that checks bytes
// against a queue of accepted writes, and one task per scenario.
module tb_iobus_uart_tx;

    localparam int          DIV  = (50 * 1_000_000) / 115200;  // 434
    localparam logic [31:0] BASE = 32'h1100_0100;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr    = 32'h0;
    logic [31:0] wdata   = 32'h0;
    logic        wr      = 1'b0;
    logic [31:0] rd_data;
    logic        tx;
    logic        irq;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [7:0]  exp_q[$];

    iobus_uart_tx dut (
        .CLK        (clk),
        .RESET_N    (reset_n),
        .IOBUS_ADDR (addr),
        .IOBUS_OUT  (wdata),
        .IOBUS_WR   (wr),
        .RD_DATA    (rd_data),
        .TX         (tx),
        .IRQ        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance one clock; all sampling and driving happens 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
        addr  = 32'h0;
        $display("write addr=%h data=%h", a, d);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        tick();
        d    = rd_data;
        addr = 32'h0;
        $display("read  addr=%h data=%h", a, d);
    endtask

    // Wait for a start bit, sample each bit mid-cell, compare with the scoreboard.
    task automatic receive_frame(input int timeout, output int start_cyc);
        int         waited;
        logic [7:0] got;
        logic [7:0] exp;
        waited = 0;
        while (tx !== 1'b0 && waited < timeout) begin
            tick();
            waited++;
        end
        start_cyc = cyc;
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL frame_start: tx=%b, required 0 within %0d cycles", tx, timeout);
            return;
        end
        repeat (DIV / 2) tick();
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL start_bit: tx=%b, required 0", tx);
        end
        for (int k = 0; k < 8; k++) begin
            repeat (DIV) tick();
            got[k] = tx;
        end
        repeat (DIV) tick();
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL stop_bit: tx=%b, required 1", tx);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got byte %h, required no frame", got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL frame_data: got %h, required %h", got, exp);
            end
        end
        $display("frame start_cyc=%0d byte=%h", start_cyc, got);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        addr    = BASE + 32'h8;
        repeat (3) tick();
        checks++;
        if (tx !== 1'b1 || irq !== 1'b0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: tx=%b irq=%b rd=%h, required 1 0 0", tx, irq, rd_data);
        end
        reset_n = 1'b1;
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL reset_status: got %h, required %h", d, 32'h2);
        end
        bus_read(BASE + 32'h8, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL reset_ctrl: got %h, required %h", d, 32'h1);
        end
    endtask

    // 0x55 frame checked cycle by cycle for exact bit timing.
    task automatic test_single_frame();
        logic [9:0]  frame;
        logic [7:0]  got;
        logic [7:0]  exp;
        logic [31:0] d;
        int          bad;
        frame = {1'b1, 8'h55, 1'b0};
        exp_q.push_back(8'h55);
        bus_write(BASE, 32'h55);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL tx_before_fall: tx=%b, required 1", tx);
        end
        tick();
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL tx_fall_latency: tx=%b one cycle after push, required 0", tx);
        end
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int c = 0; c < DIV; c++) begin
                if (tx !== frame[k]) bad++;
                if (c == DIV / 2 && k >= 1 && k <= 8) got[k-1] = tx;
                tick();
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL bit_timing_%0d: %0d cycles wrong, required %b for %0d cycles",
                         k, bad, frame[k], DIV);
            end
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL line_idle_after_frame: tx=%b, required 1", tx);
        end
        checks++;
        exp = exp_q.pop_front();
        if (got !== exp) begin
            errors++;
            $display("FAIL single_frame_data: got %h, required %h", got, exp);
        end
        $display("frame byte=%h (single)", got);
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL single_frame_status: got %h, required %h", d, 32'h2);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int          model_count;
        bus_write(BASE + 32'h8, 32'h0);
        model_count = 0;
        for (int i = 0; i < 9; i++) begin
            if (model_count < 8) begin
                exp_q.push_back(8'(i));
                model_count++;
            end
            bus_write(BASE, 32'(i));
        end
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h89) begin
            errors++;
            $display("FAIL overflow_status: got %h, required %h", d, 32'h89);
        end
        bus_write(BASE + 32'h4, 32'h0);
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h81) begin
            errors++;
            $display("FAIL overflow_clear: got %h, required %h", d, 32'h81);
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL tx_disabled_idle: tx=%b, required 1", tx);
        end
    endtask

    task automatic test_back_to_back();
        int          starts[8];
        logic [31:0] d;
        bus_write(BASE + 32'h8, 32'h1);
        for (int i = 0; i < 8; i++) begin
            receive_frame((i == 0) ? 10 : DIV + 10, starts[i]);
            if (i > 0) begin
                checks++;
                if (starts[i] - starts[i-1] != 10 * DIV + 1) begin
                    errors++;
                    $display("FAIL frame_spacing_%0d: got %0d cycles, required %0d",
                             i, starts[i] - starts[i-1], 10 * DIV + 1);
                end
            end
        end
        repeat (DIV) tick();
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL drained_status: got %h, required %h", d, 32'h2);
        end
    endtask

    task automatic test_irq();
        int start_cyc;
        bus_write(BASE + 32'h8, 32'h3);
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_idle_empty: irq=%b, required 1", irq);
        end
        exp_q.push_back(8'h3C);
        bus_write(BASE, 32'h3C);
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_after_push: irq=%b, required 0", irq);
        end
        receive_frame(10, start_cyc);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_busy: irq=%b, required 0", irq);
        end
        while (cyc < start_cyc + 10 * DIV) tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_at_idle_edge: irq=%b, required 0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise: irq=%b, required 1", irq);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int          waited;
        int          low_cycles;
        bus_write(BASE, 32'hA6);
        waited = 0;
        while (tx !== 1'b0 && waited < 10) begin
            tick();
            waited++;
        end
        repeat (4 * DIV + DIV / 2) tick();
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL data_bit3_before_reset: tx=%b, required 0", tx);
        end
        reset_n = 1'b0;
        addr    = BASE + 32'h8;
        tick();
        checks++;
        if (tx !== 1'b1 || irq !== 1'b0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort: tx=%b irq=%b rd=%h, required 1 0 0", tx, irq, rd_data);
        end
        tick();
        reset_n = 1'b1;
        addr    = 32'h0;
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL post_reset_status: got %h, required %h", d, 32'h2);
        end
        bus_read(BASE + 32'h8, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL post_reset_ctrl: got %h, required %h", d, 32'h1);
        end
        low_cycles = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            if (tx !== 1'b1) low_cycles++;
            tick();
        end
        checks++;
        if (low_cycles != 0) begin
            errors++;
            $display("FAIL post_reset_line: %0d low cycles, required 0", low_cycles);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        int          low_cycles;
        bus_write(BASE + 32'hC, 32'h77);
        bus_write(BASE + 32'h1, 32'h78);
        bus_write(BASE + 32'h9, 32'h0);
        low_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            if (tx !== 1'b1) low_cycles++;
            tick();
        end
        checks++;
        if (low_cycles != 0) begin
            errors++;
            $display("FAIL decode_no_frame: %0d low cycles, required 0", low_cycles);
        end
        bus_read(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL decode_status: got %h, required %h", d, 32'h2);
        end
        bus_read(BASE + 32'hC, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL decode_read_miss: got %h, required %h", d, 32'h0);
        end
        bus_read(BASE, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL txdata_read: got %h, required %h", d, 32'h0);
        end
        bus_read(BASE + 32'h8, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL misaligned_ctrl_write: got %h, required %h", d, 32'h1);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_irq();
        test_reset_mid_frame();
        test_decode();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d bytes pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
